// File: rtl/usb_link_tx_control_pkg.sv
// Shared types and constants for the USB link-layer transmit multiplexer.
package usb_link_tx_control_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StToken = 2'd1,
        StData  = 2'd2
    } tx_state_e;

    localparam logic [7:0] PidOut   = 8'hE1;
    localparam logic [7:0] PidIn    = 8'h69;
    localparam logic [7:0] PidAck   = 8'hD2;
    localparam logic [7:0] PidData0 = 8'hC3;

endpackage

// File: rtl/usb_link_tx_control_if.sv
// Token, data and PHY byte streams plus link-control strobes for the TX mux.
interface usb_link_tx_control_if;

    logic       tx_data_on;
    logic       tx_lp_eop_en;

    logic       tx_to_sop;
    logic       tx_to_eop;
    logic       tx_to_valid;
    logic [7:0] tx_to_data;
    logic       tx_to_ready;

    logic       tx_lt_sop;
    logic       tx_lt_eop;
    logic       tx_lt_valid;
    logic [7:0] tx_lt_data;
    logic       tx_lt_cancle;
    logic       tx_lt_ready;

    logic       tx_lp_sop;
    logic       tx_lp_eop;
    logic       tx_lp_valid;
    logic [7:0] tx_lp_data;
    logic       tx_lp_cancle;
    logic       tx_lp_ready;

    modport slave (
        input  tx_data_on,
        input  tx_to_sop, tx_to_eop, tx_to_valid, tx_to_data,
        input  tx_lt_sop, tx_lt_eop, tx_lt_valid, tx_lt_data, tx_lt_cancle,
        input  tx_lp_ready,
        output tx_lp_eop_en, tx_to_ready, tx_lt_ready,
        output tx_lp_sop, tx_lp_eop, tx_lp_valid, tx_lp_data, tx_lp_cancle
    );

    modport master (
        output tx_data_on,
        output tx_to_sop, tx_to_eop, tx_to_valid, tx_to_data,
        output tx_lt_sop, tx_lt_eop, tx_lt_valid, tx_lt_data, tx_lt_cancle,
        output tx_lp_ready,
        input  tx_lp_eop_en, tx_to_ready, tx_lt_ready,
        input  tx_lp_sop, tx_lp_eop, tx_lp_valid, tx_lp_data, tx_lp_cancle
    );

endinterface

// File: rtl/usb_link_tx_control_tx_src_mux.sv
// Combinational 2:1 stream mux: forwards the selected source, routes ready back only to it.
module tx_src_mux (
    input  logic       sel_data_i,

    input  logic       to_sop_i,
    input  logic       to_eop_i,
    input  logic       to_valid_i,
    input  logic [7:0] to_data_i,
    output logic       to_ready_o,

    input  logic       lt_sop_i,
    input  logic       lt_eop_i,
    input  logic       lt_valid_i,
    input  logic [7:0] lt_data_i,
    output logic       lt_ready_o,

    output logic       out_sop_o,
    output logic       out_eop_o,
    output logic       out_valid_o,
    output logic [7:0] out_data_o,
    input  logic       out_ready_i
);

    always_comb begin
        out_sop_o   = to_sop_i;
        out_eop_o   = to_eop_i;
        out_valid_o = to_valid_i;
        out_data_o  = to_data_i;
        to_ready_o  = out_ready_i;
        lt_ready_o  = 1'b0;
        if (sel_data_i) begin
            out_sop_o   = lt_sop_i;
            out_eop_o   = lt_eop_i;
            out_valid_o = lt_valid_i;
            out_data_o  = lt_data_i;
            to_ready_o  = 1'b0;
            lt_ready_o  = out_ready_i;
        end
    end

endmodule

// File: rtl/usb_link_tx_control.sv
// USB link TX mux: locks the token or data source for a whole packet onto the PHY stream
// and reports each packet end to link control.
module usb_link_tx_control
    import usb_link_tx_control_pkg::*;
(
    input logic                  clk,
    input logic                  rst,
    usb_link_tx_control_if.slave tx_io
);

    tx_state_e  state_q, state_d;
    logic       eop_en_q, eop_en_d;

    logic       sel_data;
    logic       src_sop, src_eop, src_valid;
    logic [7:0] src_data;
    logic       src_ready;
    logic       drop;
    logic       lp_valid;
    logic       hs;

    // Selection is only free to follow tx_data_on while no packet is open.
    always_comb begin
        sel_data = tx_io.tx_data_on;
        if (state_q == StToken) sel_data = 1'b0;
        if (state_q == StData)  sel_data = 1'b1;
    end

    // A non-sop beat in IDLE has no packet to belong to; swallow it.
    assign drop      = (state_q == StIdle) & src_valid & ~src_sop;
    assign src_ready = ~rst & (drop | tx_io.tx_lp_ready);

    tx_src_mux u_tx_src_mux (
        .sel_data_i  (sel_data),
        .to_sop_i    (tx_io.tx_to_sop),
        .to_eop_i    (tx_io.tx_to_eop),
        .to_valid_i  (tx_io.tx_to_valid),
        .to_data_i   (tx_io.tx_to_data),
        .to_ready_o  (tx_io.tx_to_ready),
        .lt_sop_i    (tx_io.tx_lt_sop),
        .lt_eop_i    (tx_io.tx_lt_eop),
        .lt_valid_i  (tx_io.tx_lt_valid),
        .lt_data_i   (tx_io.tx_lt_data),
        .lt_ready_o  (tx_io.tx_lt_ready),
        .out_sop_o   (src_sop),
        .out_eop_o   (src_eop),
        .out_valid_o (src_valid),
        .out_data_o  (src_data),
        .out_ready_i (src_ready)
    );

    assign lp_valid           = ~rst & src_valid & ~drop;
    assign hs                 = lp_valid & tx_io.tx_lp_ready;

    assign tx_io.tx_lp_valid  = lp_valid;
    assign tx_io.tx_lp_sop    = ~rst & src_sop & ~drop;
    assign tx_io.tx_lp_eop    = ~rst & src_eop & ~drop;
    assign tx_io.tx_lp_data   = rst ? 8'h00 : src_data;
    assign tx_io.tx_lp_cancle = ~rst & sel_data & tx_io.tx_lt_cancle;
    assign tx_io.tx_lp_eop_en = ~rst & eop_en_q;

    always_comb begin
        state_d  = state_q;
        eop_en_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (hs && src_sop && !src_eop) state_d = sel_data ? StData : StToken;
            end
            StToken: begin
                if (hs && src_eop) state_d = StIdle;
            end
            StData: begin
                if ((hs && src_eop) || tx_io.tx_lt_cancle) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Cancel and eop on the same beat still yield a single pulse.
        eop_en_d = (hs & src_eop) | ((state_q == StData) & tx_io.tx_lt_cancle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            eop_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            eop_en_q <= eop_en_d;
        end
    end

endmodule

// File: tb/tb_usb_link_tx_control.sv
// Directed bench for usb_link_tx_control: vector table plus multi-cycle stall/reset sequences.
module tb_usb_link_tx_control;
    import usb_link_tx_control_pkg::*;

    typedef struct packed {
        logic       rst;
        logic       on;
        logic       to_sop;
        logic       to_eop;
        logic       to_valid;
        logic [7:0] to_data;
        logic       lt_sop;
        logic       lt_eop;
        logic       lt_valid;
        logic [7:0] lt_data;
        logic       canc;
        logic       rdy;
    } stim_t;

    typedef struct packed {
        logic       valid;
        logic       sop;
        logic       eop;
        logic [7:0] data;
        logic       canc;
        logic       to_rdy;
        logic       lt_rdy;
        logic       eop_en;
        logic [1:0] state;
    } want_t;

    typedef struct packed {
        stim_t stim;
        want_t want;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t tbl[$];

    usb_link_tx_control_if bus ();

    usb_link_tx_control dut (
        .clk   (clk),
        .rst   (rst),
        .tx_io (bus)
    );

    always #5 clk = ~clk;

    function automatic stim_t mk_in(logic r, logic on, logic ts, logic te, logic tv,
                                    logic [7:0] td, logic ls, logic le, logic lv,
                                    logic [7:0] ld, logic c, logic rdy);
        stim_t s;
        s = '{rst: r, on: on, to_sop: ts, to_eop: te, to_valid: tv, to_data: td,
              lt_sop: ls, lt_eop: le, lt_valid: lv, lt_data: ld, canc: c, rdy: rdy};
        return s;
    endfunction

    function automatic want_t mk_ex(logic v, logic s, logic e, logic [7:0] d, logic c,
                                    logic tr, logic lr, logic ee, tx_state_e st);
        want_t w;
        w = '{valid: v, sop: s, eop: e, data: d, canc: c, to_rdy: tr, lt_rdy: lr,
              eop_en: ee, state: st};
        return w;
    endfunction

    task automatic drive(input stim_t s);
        rst              = s.rst;
        bus.tx_data_on   = s.on;
        bus.tx_to_sop    = s.to_sop;
        bus.tx_to_eop    = s.to_eop;
        bus.tx_to_valid  = s.to_valid;
        bus.tx_to_data   = s.to_data;
        bus.tx_lt_sop    = s.lt_sop;
        bus.tx_lt_eop    = s.lt_eop;
        bus.tx_lt_valid  = s.lt_valid;
        bus.tx_lt_data   = s.lt_data;
        bus.tx_lt_cancle = s.canc;
        bus.tx_lp_ready  = s.rdy;
    endtask

    task automatic check(input string name, input want_t w);
        want_t a;
        a = {bus.tx_lp_valid, bus.tx_lp_sop, bus.tx_lp_eop, bus.tx_lp_data, bus.tx_lp_cancle,
             bus.tx_to_ready, bus.tx_lt_ready, bus.tx_lp_eop_en, 2'(dut.state_q)};
        n_vec++;
        if (a !== w) begin
            n_err++;
            $display("FAIL %s @%0t: got v=%b s=%b e=%b d=%h c=%b tr=%b lr=%b ee=%b st=%0d, want v=%b s=%b e=%b d=%h c=%b tr=%b lr=%b ee=%b st=%0d",
                     name, $time, a.valid, a.sop, a.eop, a.data, a.canc, a.to_rdy, a.lt_rdy,
                     a.eop_en, a.state, w.valid, w.sop, w.eop, w.data, w.canc, w.to_rdy,
                     w.lt_rdy, w.eop_en, w.state);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled 2 units later.
    task automatic step(input stim_t s, input want_t w, input string name);
        drive(s);
        #2;
        check(name, w);
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input stim_t s, input want_t w);
        tbl.push_back('{stim: s, want: w});
    endfunction

    initial begin
        logic [7:0] tok [3];
        logic       r;
        logic [7:0] d;
        tx_state_e  st;

        tok[0] = PidOut;
        tok[1] = 8'h08;
        tok[2] = 8'h58;

        // Reset held with a live token beat on the input
        add(mk_in(1,0, 1,0,1,PidOut, 0,0,0,8'h00, 0,1), mk_ex(0,0,0,8'h00,0, 0,0,0, StIdle));
        // Token packet, ready high
        add(mk_in(0,0, 1,0,1,PidOut, 0,0,0,8'h00, 0,1), mk_ex(1,1,0,PidOut,0, 1,0,0, StIdle));
        add(mk_in(0,0, 0,0,1,8'h08,  0,0,0,8'h00, 0,1), mk_ex(1,0,0,8'h08,0,  1,0,0, StToken));
        add(mk_in(0,0, 0,1,1,8'h58,  0,0,0,8'h00, 0,1), mk_ex(1,0,1,8'h58,0,  1,0,0, StToken));
        add(mk_in(0,0, 0,0,0,8'h00,  0,0,0,8'h00, 0,1), mk_ex(0,0,0,8'h00,0,  1,0,1, StIdle));
        add(mk_in(0,0, 0,0,0,8'h00,  0,0,0,8'h00, 0,1), mk_ex(0,0,0,8'h00,0,  1,0,0, StIdle));
        // Data packet cancelled on the 4th byte, then orphan beats discarded
        add(mk_in(0,1, 0,0,0,8'h00, 1,0,1,PidData0, 0,1), mk_ex(1,1,0,PidData0,0, 0,1,0, StIdle));
        add(mk_in(0,1, 0,0,0,8'h00, 0,0,1,8'h01,    0,1), mk_ex(1,0,0,8'h01,0,    0,1,0, StData));
        add(mk_in(0,1, 0,0,0,8'h00, 0,0,1,8'h02,    0,1), mk_ex(1,0,0,8'h02,0,    0,1,0, StData));
        add(mk_in(0,1, 0,0,0,8'h00, 0,0,1,8'h03,    1,1), mk_ex(1,0,0,8'h03,1,    0,1,0, StData));
        add(mk_in(0,1, 0,0,0,8'h00, 0,0,1,8'h04,    0,1), mk_ex(0,0,0,8'h04,0,    0,1,1, StIdle));
        add(mk_in(0,1, 0,0,0,8'h00, 0,1,1,8'h05,    0,1), mk_ex(0,0,0,8'h05,0,    0,1,0, StIdle));
        // Single-byte handshake
        add(mk_in(0,0, 1,1,1,PidAck, 0,0,0,8'h00, 0,1), mk_ex(1,1,1,PidAck,0, 1,0,0, StIdle));
        add(mk_in(0,0, 0,0,0,8'h00,  0,0,0,8'h00, 0,1), mk_ex(0,0,0,8'h00,0,  1,0,1, StIdle));
        // Lock: tx_data_on rises mid-token; cancel on the token path has no effect
        add(mk_in(0,0, 1,0,1,PidIn, 0,0,0,8'h00,    0,1), mk_ex(1,1,0,PidIn,0,    1,0,0, StIdle));
        add(mk_in(0,1, 0,0,1,8'h10, 1,0,1,PidData0, 1,1), mk_ex(1,0,0,8'h10,0,    1,0,0, StToken));
        add(mk_in(0,1, 0,1,1,8'h80, 1,0,1,PidData0, 0,1), mk_ex(1,0,1,8'h80,0,    1,0,0, StToken));
        add(mk_in(0,1, 0,0,0,8'h00, 1,0,1,PidData0, 0,1), mk_ex(1,1,0,PidData0,0, 0,1,1, StIdle));
        add(mk_in(0,1, 0,0,0,8'h00, 0,1,1,8'h11,    0,1), mk_ex(1,0,1,8'h11,0,    0,1,0, StData));
        add(mk_in(0,0, 0,0,0,8'h00, 0,0,0,8'h00,    0,1), mk_ex(0,0,0,8'h00,0,    1,0,1, StIdle));

        drive(mk_in(1,0, 0,0,0,8'h00, 0,0,0,8'h00, 0,0));
        repeat (2) @(posedge clk);
        #1;

        foreach (tbl[i]) step(tbl[i].stim, tbl[i].want, $sformatf("tbl[%0d]", i));

        // Token E1 08 58 with 32 stalled cycles per byte
        for (int b = 0; b < 3; b++) begin
            for (int c = 0; c < 33; c++) begin
                r  = (c == 32);
                st = (b == 0) ? StIdle : StToken;
                step(mk_in(0,0, b==0,b==2,1,tok[b], 0,0,0,8'h00, 0,r),
                     mk_ex(1,b==0,b==2,tok[b],0, r,0,0, st), "tok_bp");
            end
        end
        step(mk_in(0,0, 0,0,0,8'h00, 0,0,0,8'h00, 0,1), mk_ex(0,0,0,8'h00,0, 1,0,1, StIdle),
             "tok_eop_en");
        step(mk_in(0,0, 0,0,0,8'h00, 0,0,0,8'h00, 0,1), mk_ex(0,0,0,8'h00,0, 1,0,0, StIdle),
             "tok_eop_en_clr");

        // Data C3 01..0F, ready high one cycle in 33
        for (int b = 0; b < 16; b++) begin
            d  = (b == 0) ? PidData0 : 8'(b);
            st = (b == 0) ? StIdle : StData;
            for (int c = 0; c < 33; c++) begin
                r = (c == 32);
                step(mk_in(0,1, 0,0,0,8'h00, b==0,b==15,1,d, 0,r),
                     mk_ex(1,b==0,b==15,d,0, 0,r,0, st), "data_bp");
            end
        end
        step(mk_in(0,1, 0,0,0,8'h00, 0,0,0,8'h00, 0,1), mk_ex(0,0,0,8'h00,0, 0,1,1, StIdle),
             "data_eop_en");
        step(mk_in(0,1, 0,0,0,8'h00, 0,0,0,8'h00, 0,1), mk_ex(0,0,0,8'h00,0, 0,1,0, StIdle),
             "data_eop_en_clr");

        // Single-byte ACK stalled 32 cycles
        for (int c = 0; c < 33; c++) begin
            r = (c == 32);
            step(mk_in(0,0, 1,1,1,PidAck, 0,0,0,8'h00, 0,r), mk_ex(1,1,1,PidAck,0, r,0,0, StIdle),
                 "ack_bp");
        end
        step(mk_in(0,0, 0,0,0,8'h00, 0,0,0,8'h00, 0,1), mk_ex(0,0,0,8'h00,0, 1,0,1, StIdle),
             "ack_eop_en");

        // Reset in the middle of a data packet
        step(mk_in(0,1, 0,0,0,8'h00, 1,0,1,PidData0, 0,1), mk_ex(1,1,0,PidData0,0, 0,1,0, StIdle),
             "rst_pre_sop");
        step(mk_in(0,1, 0,0,0,8'h00, 0,0,1,8'h01, 0,1), mk_ex(1,0,0,8'h01,0, 0,1,0, StData),
             "rst_pre_body");
        step(mk_in(1,1, 0,0,0,8'h00, 0,0,1,8'h02, 1,1), mk_ex(0,0,0,8'h00,0, 0,0,0, StData),
             "rst_held");
        step(mk_in(0,1, 0,0,0,8'h00, 0,0,1,8'h03, 0,1), mk_ex(0,0,0,8'h03,0, 0,1,0, StIdle),
             "rst_orphan_drop");
        step(mk_in(0,1, 0,0,0,8'h00, 1,0,1,PidData0, 0,1), mk_ex(1,1,0,PidData0,0, 0,1,0, StIdle),
             "rst_new_sop");
        step(mk_in(0,1, 0,0,0,8'h00, 0,1,1,8'h04, 0,1), mk_ex(1,0,1,8'h04,0, 0,1,0, StData),
             "rst_new_eop");
        step(mk_in(0,1, 0,0,0,8'h00, 0,0,0,8'h00, 0,1), mk_ex(0,0,0,8'h00,0, 0,1,1, StIdle),
             "rst_new_eop_en");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/usb_link_tx_control.md
# usb_link_tx_control

USB link-layer transmit multiplexer between the TX packet sources and the PHY. It forwards token/handshake packets from the CRC5 generator (`to` path) and data packets from the link layer (`lt` path) onto the single PHY byte stream (`lp` path). A data-phase flag from link control selects the source, and the block locks that selection for a whole packet. It reports the end of every transmitted packet back to link control.

## Interface
- Parameters: none.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tx_data_on`  in  1  from link control; 1 selects the data (`lt`) path, 0 selects the token (`to`) path.
- `tx_lp_eop_en`  out  1  one-cycle end-of-packet pulse to link control.
- `tx_to_sop`, `tx_to_eop`, `tx_to_valid`  in  1 each  token/handshake stream control.
- `tx_to_data`  in  8  token/handshake byte (PID first).
- `tx_to_ready`  out  1  token stream backpressure.
- `tx_lt_sop`, `tx_lt_eop`, `tx_lt_valid`  in  1 each  data stream control.
- `tx_lt_data`  in  8  data byte (PID first).
- `tx_lt_cancle`  in  1  abort the current data packet.
- `tx_lt_ready`  out  1  data stream backpressure.
- `tx_lp_sop`, `tx_lp_eop`, `tx_lp_valid`  out  1 each  PHY stream control.
- `tx_lp_data`  out  8  PHY byte.
- `tx_lp_cancle`  out  1  abort to the PHY.
- `tx_lp_ready`  in  1  PHY accepts a byte when high together with `tx_lp_valid`.

## Operation
- States:
  - IDLE: no packet open.
  - TOKEN: `to` packet open.
  - DATA: `lt` packet open.
- Source select `sel_data`:
  - In IDLE it is `tx_data_on`.
  - In TOKEN it is 0.
  - In DATA it is 1.
- Datapath is combinational (zero latency). The selected source's sop/eop/valid/data drive `tx_lp_*`.
- Ready routing:
  - Selected source: `*_ready = tx_lp_ready`.
  - Unselected source: ready = 0.
- `tx_lp_cancle = sel_data & tx_lt_cancle`. The `to` path has no cancel.
- A handshake is valid & ready on the PHY side.
- Transitions:
  - IDLE→TOKEN: handshake on a `to` sop beat without eop.
  - IDLE→DATA: handshake on an `lt` sop beat without eop.
  - TOKEN/DATA→IDLE: handshake on an eop beat.
  - DATA→IDLE: also on `tx_lt_cancle` = 1, with or without a handshake.
  - A single-byte packet (sop & eop on the same beat) stays in IDLE.
- Non-sop beat from the selected source while in IDLE:
  - The beat is discarded: source ready = 1, `tx_lp_valid` = 0.
  - This applies whether or not the beat carries eop.
- `tx_data_on` changes while a packet is open:
  - They are ignored until return to IDLE, so no packet is ever interleaved or truncated.
  - The newly selected source waits with ready = 0.
- `tx_lp_eop_en`: registered. It is 1 for exactly the cycle after any eop handshake or a data-path cancel, otherwise 0.

## Timing
- Data latency: 0 cycles, input byte to `tx_lp_data`.
- State and `tx_lp_eop_en` update on the clock edge after the qualifying handshake.
- Backpressure: while `tx_lp_ready` = 0, the selected source must hold its data. The block adds no buffering, and hold duration is unbounded.
- Reset asserted:
  - State forced to IDLE.
  - `tx_lp_valid`, `tx_lp_sop`, `tx_lp_eop`, `tx_lp_cancle`, `tx_to_ready`, `tx_lt_ready`, and `tx_lp_eop_en` all 0.
  - `tx_lp_data` = 8'h00.
- Reset mid-packet: the packet is dropped with no `tx_lp_eop_en`. After release the block waits for a new sop.
- Simultaneous cancel and eop handshake: one `tx_lp_eop_en` pulse only.

## Structure
- Shared package holds:
  - State encoding constants: IDLE=2'd0, TOKEN=2'd1, DATA=2'd2.
  - PID constants used by benches: OUT 8'hE1, IN 8'h69, ACK 8'hD2, DATA0 8'hC3.
- One sub-module is natural: `tx_src_mux`, a pure combinational 2:1 stream mux taking `sel_data`. The FSM and pulse register live in the top.

## Test plan
- Token with backpressure: `tx_data_on`=0; send E1, 08, 58 (eop on 58); `tx_lp_ready` low for 32 cycles per byte → `tx_lp_data` shows E1, 08, 58 unchanged while held; `tx_to_ready` mirrors `tx_lp_ready`; `tx_lp_eop_en` pulses once after the 58 handshake; `tx_lt_ready`=0 throughout.
- Data packet: `tx_data_on`=1; send C3, 01, 02…0F with ready pulsing one cycle in 33 → bytes appear in order; `tx_to_ready`=0; state DATA until 0F eop; single `tx_lp_eop_en` pulse.
- Handshake single byte: `tx_data_on`=0; D2 with sop=eop=1; ready stalls for 32 cycles → one PHY beat D2 with sop=eop=1; state stays IDLE; `tx_lp_eop_en` pulses.
- Lock: raise `tx_data_on` in the middle of a token packet → the token completes unbroken; the `lt` sop waits (`tx_lt_ready`=0) until IDLE, then C3 is forwarded.
- Cancel: assert `tx_lt_cancle` after the 3rd data byte → `tx_lp_cancle`=1 the same cycle; state returns to IDLE; one eop_en pulse; later beats without sop are discarded.
- Reset: assert `rst` in the middle of a data packet → all outputs 0 the next cycle; after release a non-sop beat is discarded and a new sop packet passes.
